// File: rtl/spi_device.sv
// SPI target: oversamples SCK/CS_N/MOSI in the clk_i domain and moves LSB-first bytes
// between the serial pins and valid/ready RX/TX ports.
module spi_device #(
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sck_i,
  input  logic       cs_ni,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       rx_overrun_o,
  output logic       tx_underrun_o,
  output logic       busy_o
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d, cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d, cs_prev_q, cs_prev_d;
  logic                   mosi_smp_q, mosi_smp_d, lead_q, lead_d, trail_q, trail_d;
  state_e                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [7:0]             rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic [7:0]             tx_hold_q, tx_hold_d, rx_data_q, rx_data_d;
  logic                   tx_full_q, tx_full_d, miso_q, miso_d;
  logic                   rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d;
  logic                   tx_underrun_q, tx_underrun_d;

  logic       sck_s, cs_s, mosi_s, cs_fall, cs_rise, active;
  logic       lead, trail, sample_edge, shift_edge, byte_end, byte_start;
  logic [7:0] rx_byte;

  assign sck_s   = sck_sync_q[SYNC_STAGES-1];
  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign cs_fall = cs_prev_q & ~cs_s;
  assign cs_rise = ~cs_prev_q & cs_s;
  assign active  = (state_q == StActive);

  // Edge pulses are registered, so mosi is delayed one cycle to stay aligned with them.
  assign lead        = lead_q & active;
  assign trail       = trail_q & active;
  assign sample_edge = CPHA ? trail : lead;
  assign shift_edge  = CPHA ? lead : trail;
  // Mode 0/2 samples bit 7 on the lead, so the counter has already wrapped at its trail.
  assign byte_end    = CPHA ? (cnt_q == 3'd7) : (cnt_q == 3'd0);
  assign byte_start  = cs_fall | (trail & byte_end);
  assign rx_byte     = {mosi_smp_q, rx_shift_q[7:1]};

  always_comb begin
    sck_sync_d    = {sck_sync_q[SYNC_STAGES-2:0], sck_i};
    cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], cs_ni};
    mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
    sck_prev_d    = sck_s;
    cs_prev_d     = cs_s;
    mosi_smp_d    = mosi_s;
    lead_d        = (sck_s != sck_prev_q) & (sck_prev_q == CPOL) & ~cs_s;
    trail_d       = (sck_s != sck_prev_q) & (sck_prev_q != CPOL) & ~cs_s;
    state_d       = state_q;
    cnt_d         = cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    tx_hold_d     = tx_hold_q;
    tx_full_d     = tx_full_q;
    miso_d        = miso_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q & ~rx_ready_i;
    rx_overrun_d  = 1'b0;
    tx_underrun_d = 1'b0;

    if (cs_fall) begin
      state_d = StActive;
    end else if (cs_rise) begin
      state_d = StIdle;
    end

    if (cs_rise) begin
      cnt_d      = 3'd0;
      rx_shift_d = 8'h00;
      tx_shift_d = 8'h00;
      miso_d     = 1'b0;
    end else begin
      if (cs_fall) begin
        cnt_d      = 3'd0;
        rx_shift_d = 8'h00;
      end
      if (byte_start) begin
        if (tx_full_q) begin
          tx_shift_d = tx_hold_q;
          tx_full_d  = 1'b0;
        end else begin
          tx_shift_d    = 8'hFF;
          tx_underrun_d = 1'b1;
        end
      end else if (shift_edge) begin
        miso_d     = tx_shift_q[0];
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
      end
      if (sample_edge) begin
        rx_shift_d = rx_byte;
        cnt_d      = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          rx_data_d    = rx_byte;
          rx_valid_d   = 1'b1;
          rx_overrun_d = rx_valid_q & ~rx_ready_i;
        end
      end
    end

    // Accept only when empty, so this never collides with a byte start draining the register.
    if (tx_valid_i && !tx_full_q) begin
      tx_hold_d = tx_data_i;
      tx_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync_q    <= {SYNC_STAGES{CPOL}};
      cs_sync_q     <= '1;
      mosi_sync_q   <= '0;
      sck_prev_q    <= CPOL;
      cs_prev_q     <= 1'b1;
      mosi_smp_q    <= 1'b0;
      lead_q        <= 1'b0;
      trail_q       <= 1'b0;
      state_q       <= StIdle;
      cnt_q         <= 3'd0;
      rx_shift_q    <= 8'h00;
      tx_shift_q    <= 8'h00;
      tx_hold_q     <= 8'h00;
      tx_full_q     <= 1'b0;
      miso_q        <= 1'b0;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      sck_sync_q    <= sck_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sck_prev_q    <= sck_prev_d;
      cs_prev_q     <= cs_prev_d;
      mosi_smp_q    <= mosi_smp_d;
      lead_q        <= lead_d;
      trail_q       <= trail_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      tx_hold_q     <= tx_hold_d;
      tx_full_q     <= tx_full_d;
      miso_q        <= miso_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign miso_o        = CPHA ? miso_q : tx_shift_q[0];
  assign miso_oe_o     = active;
  assign busy_o        = active;
  assign tx_ready_o    = ~tx_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_overrun_o  = rx_overrun_q;
  assign tx_underrun_o = tx_underrun_q;

endmodule
